atm_pin_checker: RTL and testbench

//  Upstream controller for the 16x4b PIN register file (4 accounts x 4 PIN digits, addr = {ACCT,digit}).

---
 rtl/atm_pkg.sv | 20 ++
 rtl/atm_fail_tracker.sv | 44 ++++
 rtl/atm_pin_checker.sv | 218 +++++++++++++++++++++
 tb/tb_atm_pin_checker.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM PIN checker: FSM state encoding, the cancel key
// and default sizing constants.
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        RESULT,
        NEWPIN,
        WRITE
    } state_t;

    localparam logic [3:0] KEY_CANCEL = 4'hF;

    localparam int ACCT_BITS_DEFAULT = 2;
    localparam int DIGITS_DEFAULT    = 4;
    localparam int MAX_TRIES_DEFAULT = 3;

endpackage

// File: rtl/atm_fail_tracker.sv
// Per-account saturating failure counters with sticky lock flags. The outputs
// describe the account currently addressed by acct.
module atm_fail_tracker
    import atm_pkg::*;
#(
    parameter int ACCT_BITS = ACCT_BITS_DEFAULT,
    parameter int MAX_TRIES = MAX_TRIES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    input  logic [ACCT_BITS-1:0] acct,
    output logic                 locked,
    output logic                 last_try
);

    localparam int         NACCT   = 2 ** ACCT_BITS;
    localparam logic [1:0] MAX_CNT = 2'(MAX_TRIES);

    logic [1:0] fail_cnt [NACCT];
    logic       lock_flag[NACCT];

    // The failure that brings the count to MAX_CNT also sets the lock; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NACCT; i++) begin
                fail_cnt[i]  <= '0;
                lock_flag[i] <= 1'b0;
            end
        end else if (clr) begin
            fail_cnt[acct] <= '0;
        end else if (inc && (fail_cnt[acct] != MAX_CNT)) begin
            fail_cnt[acct] <= fail_cnt[acct] + 2'd1;
            if (fail_cnt[acct] == MAX_CNT - 2'd1) begin
                lock_flag[acct] <= 1'b1;
            end
        end
    end

    assign locked   = lock_flag[acct];
    assign last_try = (fail_cnt[acct] == MAX_CNT - 2'd1);

endmodule

// File: rtl/atm_pin_checker.sv
// ATM PIN checker: keypad entry, constant-time compare against the PIN register
// file, per-account lockout. Define ATM_PIN_CHANGE_EN to enable PIN rewrite.
module atm_pin_checker
    import atm_pkg::*;
#(
    parameter int ACCT_BITS = ACCT_BITS_DEFAULT,
    parameter int DIGITS    = DIGITS_DEFAULT,
    parameter int MAX_TRIES = MAX_TRIES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ACCT_BITS-1:0] acct,
    input  logic                 chg,
    input  logic [3:0]           key,
    input  logic                 key_vld,
    output logic                 key_rdy,
    output logic [3:0]           rf_ra,
    input  logic [3:0]           rf_data,
    output logic [3:0]           rf_wa,
    output logic [3:0]           rf_wd,
    output logic                 rf_wr,
    output logic                 busy,
    output logic                 grant,
    output logic                 deny,
    output logic                 locked,
    output logic                 done
);

    localparam int IDX_BITS = 4 - ACCT_BITS;

    state_t                state;
    state_t                state_nxt;
    logic [ACCT_BITS-1:0]  acct_q;
    logic [ACCT_BITS-1:0]  trk_acct;
    logic [IDX_BITS-1:0]   idx;
    logic [3:0]            pin_buf[DIGITS];
    logic                  mismatch;
    logic                  lock_path;
    logic                  acct_locked;
    logic                  last_try;
    logic                  fail_inc;
    logic                  fail_clr;
    logic                  accept;
    logic                  last_idx;

    assign key_rdy  = (state == COLLECT) || (state == NEWPIN);
    assign accept   = key_vld && key_rdy;
    assign last_idx = (idx == IDX_BITS'(DIGITS - 1));
    assign busy     = (state != IDLE);

    // In IDLE the lock lookup must see the account being requested, not the stale latch.
    assign trk_acct = (state == IDLE) ? acct : acct_q;

    atm_fail_tracker #(
        .ACCT_BITS(ACCT_BITS),
        .MAX_TRIES(MAX_TRIES)
    ) u_fail_tracker (
        .clk     (clk),
        .rst     (rst),
        .inc     (fail_inc),
        .clr     (fail_clr),
        .acct    (trk_acct),
        .locked  (acct_locked),
        .last_try(last_try)
    );

    // idx wraps to 0 after the last digit, so each phase starts at digit 0 without extra logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acct_q    <= '0;
            idx       <= '0;
            mismatch  <= 1'b0;
            lock_path <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                pin_buf[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acct_q    <= acct;
                        idx       <= '0;
                        mismatch  <= 1'b0;
                        lock_path <= acct_locked;
                    end
                end
                COLLECT, NEWPIN: begin
                    if (accept) begin
                        if (key == KEY_CANCEL) begin
                            idx <= '0;
                            for (int i = 0; i < DIGITS; i++) begin
                                pin_buf[i] <= '0;
                            end
                        end else begin
                            pin_buf[idx] <= key;
                            idx          <= idx + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    mismatch <= mismatch | (rf_data != pin_buf[idx]);
                    idx      <= idx + 1'b1;
                end
                WRITE: begin
                    idx <= idx + 1'b1;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

`ifdef ATM_PIN_CHANGE_EN
    logic chg_q;
    logic done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                chg_q <= chg;
            end
            done_q <= (state == WRITE) && last_idx;
        end
    end

    assign rf_wr = (state == WRITE);
    assign rf_wa = rf_wr ? {acct_q, idx} : 4'h0;
    assign rf_wd = rf_wr ? pin_buf[idx] : 4'h0;
    assign done  = done_q;
`else
    logic unused_chg;

    assign unused_chg = chg;
    assign rf_wr      = 1'b0;
    assign rf_wa      = 4'h0;
    assign rf_wd      = 4'h0;
    assign done       = 1'b0;
`endif

    // CHECK always walks every digit so the compare time never reveals where a mismatch sits.
    always_comb begin
        state_nxt = state;
        rf_ra     = 4'h0;
        grant     = 1'b0;
        deny      = 1'b0;
        locked    = 1'b0;
        fail_inc  = 1'b0;
        fail_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = acct_locked ? RESULT : COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (key == KEY_CANCEL) begin
                        state_nxt = IDLE;
                    end else if (last_idx) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                rf_ra = {acct_q, idx};
                if (last_idx) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                state_nxt = IDLE;
                if (lock_path) begin
                    deny   = 1'b1;
                    locked = 1'b1;
                end else if (mismatch) begin
                    deny     = 1'b1;
                    locked   = last_try;
                    fail_inc = 1'b1;
                end else begin
                    grant    = 1'b1;
                    fail_clr = 1'b1;
`ifdef ATM_PIN_CHANGE_EN
                    if (chg_q) begin
                        state_nxt = NEWPIN;
                    end
`endif
                end
            end
`ifdef ATM_PIN_CHANGE_EN
            NEWPIN: begin
                if (accept) begin
                    if (key == KEY_CANCEL) begin
                        state_nxt = IDLE;
                    end else if (last_idx) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last_idx) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_atm_pin_checker.sv
// Scoreboard bench for atm_pin_checker: a PIN/lockout reference model predicts each
// result pulse and its cycle; a negedge monitor pops and compares them.
module tb_atm_pin_checker;

    localparam int MAX_TRIES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  acct = 2'd0;
    logic        chg = 1'b0;
    logic [3:0]  key = 4'h0;
    logic        key_vld = 1'b0;
    logic        key_rdy;
    logic [3:0]  rf_ra;
    logic [3:0]  rf_data;
    logic [3:0]  rf_wa;
    logic [3:0]  rf_wd;
    logic        rf_wr;
    logic        busy;
    logic        grant;
    logic        deny;
    logic        locked;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [3:0]  rf_mem[16];
    logic [15:0] model_pin[4];
    int          model_fail[4];
    bit          model_lock[4];

    typedef struct {
        logic [3:0] flags;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    atm_pin_checker dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .acct   (acct),
        .chg    (chg),
        .key    (key),
        .key_vld(key_vld),
        .key_rdy(key_rdy),
        .rf_ra  (rf_ra),
        .rf_data(rf_data),
        .rf_wa  (rf_wa),
        .rf_wd  (rf_wd),
        .rf_wr  (rf_wr),
        .busy   (busy),
        .grant  (grant),
        .deny   (deny),
        .locked (locked),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rf_data = rf_mem[rf_ra];

    always @(posedge clk) begin
        if (rf_wr) rf_mem[rf_wa] <= rf_wd;
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Result pulses are matched in order against the predicted flags and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (grant || deny || locked || done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {grant, deny, locked, done}, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_flags", {grant, deny, locked, done}, e.flags);
                checkOutput("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        @(negedge clk);
        checkOutput({tag, "_ctrl"}, {key_rdy, busy, grant, deny, locked, done, rf_wr}, 0);
        checkOutput({tag, "_rf_ra"}, rf_ra, 0);
        checkOutput({tag, "_rf_wa"}, rf_wa, 0);
        checkOutput({tag, "_rf_wd"}, rf_wd, 0);
        tick();
    endtask

    task automatic modelReset();
        for (int a = 0; a < 4; a++) begin
            model_fail[a] = 0;
            model_lock[a] = 1'b0;
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        tick();
        modelReset();
        checkQuiet("reset_state");
        rst = 1'b0;
    endtask

    task automatic sendKey(input logic [3:0] k, output int acc_cyc);
        bit taken = 1'b0;
        key     = k;
        key_vld = 1'b1;
        acc_cyc = -1;
        for (int n = 0; n < 16 && !taken; n++) begin
            @(negedge clk);
            if (key_rdy) begin
                taken   = 1'b1;
                acc_cyc = cyc;
            end
            tick();
        end
        key_vld = 1'b0;
        if (!taken) checkOutput("key_accept_timeout", 0, 1);
    endtask

    function automatic logic [15:0] randPin();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[15-4*i -: 4] = 4'($urandom_range(0, 14));
        return p;
    endfunction

    // One session: START, key entry (optional cancel), compare, result, optional PIN change.
    task automatic applyStimulus(input int a, input bit c, input logic [15:0] pin,
                                 input int cancel_pos, input bit poke, input logic [15:0] new_pin);
        int  t;
        bit  match;
        bit  lk;
        start = 1'b1;
        acct  = a[1:0];
        chg   = c;
        if (model_lock[a]) begin
            exp_q.push_back('{4'b0110, cyc + 1});
            tick();
            start = 1'b0;
            chg   = 1'b0;
            @(negedge clk);
            checkOutput("locked_key_rdy", key_rdy, 0);
            tick();
            @(negedge clk);
            checkOutput("locked_busy_after", busy, 0);
            tick();
            return;
        end
        tick();
        start = 1'b0;
        chg   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (poke && i == 1) begin
                start = 1'b1;
                acct  = a[1:0] + 2'd1;
            end
            sendKey((i == cancel_pos) ? 4'hF : pin[15-4*i -: 4], t);
            start = 1'b0;
            if (i == cancel_pos) begin
                @(negedge clk);
                checkOutput("cancel_busy", busy, 0);
                tick();
                return;
            end
        end
        match = (pin == model_pin[a]);
        if (match) begin
            model_fail[a] = 0;
            exp_q.push_back('{4'b1000, t + 5});
        end else begin
            model_fail[a] = model_fail[a] + 1;
            lk = (model_fail[a] >= MAX_TRIES);
            if (lk) model_lock[a] = 1'b1;
            exp_q.push_back('{{1'b0, 1'b1, lk, 1'b0}, t + 5});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("check_rf_ra", rf_ra, a * 4 + i);
            tick();
        end
        tick();
`ifdef ATM_PIN_CHANGE_EN
        if (c && match) begin
            for (int i = 0; i < 4; i++) sendKey(new_pin[15-4*i -: 4], t);
            exp_q.push_back('{4'b0001, t + 5});
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checkOutput("write_rf_wr", rf_wr, 1);
                checkOutput("write_rf_wa", rf_wa, a * 4 + i);
                checkOutput("write_rf_wd", rf_wd, new_pin[15-4*i -: 4]);
                tick();
            end
            model_pin[a] = new_pin;
        end
`else
        if (new_pin == 16'hFFFF) checkOutput("new_pin_digit", 0, 0 + 1);
`endif
        @(negedge clk);
        checkOutput("busy_fall", busy, 0);
        tick();
    endtask

    task automatic resetInCheck(input int a, input logic [15:0] pin);
        int t;
        start = 1'b1;
        acct  = a[1:0];
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) sendKey(pin[15-4*i -: 4], t);
        tick();
        rst = 1'b1;
        tick();
        modelReset();
        checkQuiet("reset_mid_check");
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] bad;
        int          p;
        int          a;
        int          cpos;

        model_pin[0] = 16'h0E5A;
        model_pin[1] = 16'h9ABC;
        model_pin[2] = 16'h1234;
        model_pin[3] = randPin();
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 4; i++) rf_mem[n*4+i] = model_pin[n][15-4*i -: 4];

        #1;
        resetDut();

        $display("[TB] directed: grant latency and read addresses");
        applyStimulus(2, 1'b0, 16'h1234, -1, 1'b0, 16'h0);

        $display("[TB] directed: lockout after three failures");
        applyStimulus(1, 1'b0, 16'h9ABD, -1, 1'b0, 16'h0);
        applyStimulus(1, 1'b0, 16'h0000, -1, 1'b0, 16'h0);
        applyStimulus(1, 1'b0, 16'hCBA9, -1, 1'b0, 16'h0);
        applyStimulus(1, 1'b0, 16'h9ABC, -1, 1'b0, 16'h0);

        $display("[TB] directed: cancel and counter clear");
        applyStimulus(0, 1'b0, 16'h7000, 1, 1'b0, 16'h0);
        applyStimulus(0, 1'b0, 16'h0E5B, -1, 1'b0, 16'h0);
        applyStimulus(0, 1'b0, 16'hEEEE, -1, 1'b0, 16'h0);
        applyStimulus(0, 1'b0, 16'h0E5A, -1, 1'b0, 16'h0);
        applyStimulus(0, 1'b0, 16'h1111, -1, 1'b0, 16'h0);
        applyStimulus(0, 1'b0, 16'h2222, -1, 1'b0, 16'h0);
        applyStimulus(0, 1'b0, 16'h0E5A, -1, 1'b0, 16'h0);

        $display("[TB] directed: reset during compare");
        resetInCheck(3, model_pin[3]);
        applyStimulus(1, 1'b0, 16'h9ABC, -1, 1'b0, 16'h0);

        $display("[TB] directed: stray START and KEY_VLD");
        key     = 4'h3;
        key_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle_key_rdy", {key_rdy, busy}, 0);
            tick();
        end
        key_vld = 1'b0;
        applyStimulus(2, 1'b0, 16'h1234, -1, 1'b1, 16'h0);

`ifdef ATM_PIN_CHANGE_EN
        $display("[TB] directed: PIN change");
        applyStimulus(1, 1'b1, 16'h9ABC, -1, 1'b0, 16'h5678);
        applyStimulus(1, 1'b0, 16'h5678, -1, 1'b0, 16'h0);
`endif

        $display("[TB] randomized sessions");
        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 3);
            if (model_lock[a] && $urandom_range(0, 3) == 0) resetDut();
            bad = model_pin[a];
            if ($urandom_range(0, 1) == 0) begin
                p = $urandom_range(0, 3);
                bad[15-4*p -: 4] = 4'((int'(bad[15-4*p -: 4]) + 1 + $urandom_range(0, 13)) % 15);
            end
            cpos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
            applyStimulus(a, 1'($urandom_range(0, 1)), bad, cpos, 1'($urandom_range(0, 1)), randPin());
        end

        repeat (4) tick();
        checkOutput("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
